free_list: RTL
==============

// Module: free_list
// PURPOSE
//  Circular FIFO of free physical registers (PRs) for the R10000 rename path.
//  - Dispatch pops up to NUM_SUPER PRs per cycle. These become the new T tags given to the Map Table and ROB.
//  - Retire pushes each retiring instruction's Told back into the list, in the same cycle the Arch Map takes T.
//  - On a retire-time rollback (branch mispredict) the list instantly frees every allocated but uncommitted PR.
//    The Map Table is restored from arch_map in that same cycle.
// PARAMETERS
//  NUM_SUPER  2   dispatch/retire ways per cycle
//  NUM_PR     64  total physical registers
//  NUM_FL     32  ring depth = NUM_PR-32; must be a power of 2
// PORTS
//  clock          in   1                      system clock
//  reset          in   1                      synchronous, active-high; has priority over en
//  en             in   1                      global stall; when 0, all state is held
//  dispatch_en    in   NUM_SUPER              way i wants a new PR this cycle
//  retire_en      in   NUM_SUPER              way i retires an instruction with a dest; push Told_idx[i]
//  Told_idx       in   NUM_SUPER x clog2(NUM_PR)   PR freed by retiring way i
//  rollback_en    in   1                      retire-time mispredict; free all uncommitted PRs
//  T_idx          out  NUM_SUPER x clog2(NUM_PR)   PR granted to way i (combinational)
//  free_valid     out  1                      count >= NUM_SUPER; dispatch may proceed
//  free_count     out  clog2(NUM_FL)+1        number of free entries
// BEHAVIOUR
//  - Reset: ring[k] = 32+k for k = 0..NUM_FL-1; head = 0; tail = 0; count = NUM_FL.
//    Outputs at reset: free_valid = 1; T_idx[i] = 32+i.
//    This is consistent with the arch map reset value, which maps arch reg r to PR r.
//  - Pointers are clog2(NUM_FL) bits wide and wrap mod NUM_FL.
//    head == tail is ambiguous, so count alone decides full versus empty.
//  - Grant mapping is compacted. Let k_i = popcount(dispatch_en[i-1:0]).
//    Then T_idx[i] = ring[head + k_i], read combinationally from state at the start of the cycle.
//    T_idx is don't-care when dispatch_en[i] = 0.
//  - Pop size P = popcount(dispatch_en) when P <= count, otherwise 0. Dispatch is all-or-nothing.
//    The upstream stage must gate dispatch with free_valid. An over-request is dropped with no pop.
//  - Push: retiring ways are packed in way order.
//    ring[tail + popcount(retire_en[j-1:0])] <= Told_idx[j] for each set bit j.
//    Q = popcount(retire_en).
//  - Normal update (en=1, rollback_en=0): head += P; tail += Q; count <= count + Q - P.
//    No bypass: a PR pushed in cycle n can be popped no earlier than cycle n+1.
//    Push never overflows, because count + in-flight allocations = NUM_FL.
//  - Rollback (en=1, rollback_en=1):
//    - Same-cycle retire pushes are written first, giving tail' = tail + Q.
//    - Then head <= tail' and count <= NUM_FL.
//    - dispatch_en is ignored: P = 0, and no PR is granted to wrong-path instructions.
//    - The ring region [tail', old head) holds exactly the T tags of squashed instructions.
//      Moving head back to tail' frees them with no data copy.
//  - en = 0: no pops, no pushes, no rollback. Outputs still reflect the held state.
//  - A reset in the middle of operation discards all in-flight state and reloads the reset contents.
//  - Latency: grant has 0 cycles (combinational). Pointer and count updates take effect at the next posedge.
// STRUCTURE
//  - Shared package sys_defs holds:
//    - macros `NUM_SUPER, `NUM_PR and `NUM_FL;
//    - `FL_RESET (the ring contents at reset);
//    - ROB_FL_OUT_t {Told_idx[NUM_SUPER]}, the retire-side struct from the ROB;
//    - FL_MAP_TABLE_OUT_t and FL_ROB_OUT_t {T_idx[NUM_SUPER]}, the grant-side structs.
//  - One sub-module is natural: fl_popcount, a parameterised prefix popcount.
//    It is instantiated twice, once for dispatch_en and once for retire_en, and produces k_i, P and Q.
//  - Output updates use `SD, matching the rest of the pipeline.
// TESTING
//  1. Reset -> free_count=32, free_valid=1, T_idx[0]=32, T_idx[1]=33.
//  2. dispatch_en=11 -> next cycle T_idx = 34,35 and count=30.
//     Then dispatch_en=10 -> T_idx[1]=34 (compacted) and count=29.
//  3. Same cycle: dispatch_en=11 and retire_en=11 with Told=5,7 -> count unchanged.
//     After the ring wraps, 5 and 7 are granted in that order.
//  4. Dispatch 11 for 16 cycles -> count=0, free_valid=0, head wraps to 0.
//     A further dispatch_en=11 -> no pop and count stays 0.
//  5. From reset: dispatch 11 (grants 32,33), then 01 (grant 34), then retire Told=3.
//     Then rollback_en=1 with dispatch_en=11 -> count=32, no grant.
//     Next cycle T_idx = 33,34.
//  6. en=0 with dispatch and retire active -> state held.
//     reset asserted in mid-stream (count=20) -> next cycle matches scenario 1.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared rename-path definitions for the free list: sizing macros, reset contents,
// and the structs exchanged with the ROB and Map Table.
`ifndef FREE_LIST_DEFS_SVH
`define FREE_LIST_DEFS_SVH
`define NUM_SUPER 2
`define NUM_PR 64
`define NUM_FL 32
`define FL_RESET(k) (`NUM_PR - `NUM_FL + (k))
`define SD
`endif

package free_list_pkg;

    localparam int NUM_SUPER = `NUM_SUPER;
    localparam int NUM_PR    = `NUM_PR;
    localparam int NUM_FL    = `NUM_FL;
    localparam int PR_W      = $clog2(NUM_PR);
    localparam int FL_W      = $clog2(NUM_FL);
    localparam int CNT_W     = FL_W + 1;
    localparam int SC_W      = $clog2(NUM_SUPER + 1);

    typedef logic [PR_W-1:0] pr_idx_t;

    typedef struct packed {
        pr_idx_t [NUM_SUPER-1:0] Told_idx;
    } ROB_FL_OUT_t;

    typedef struct packed {
        pr_idx_t [NUM_SUPER-1:0] T_idx;
    } FL_MAP_TABLE_OUT_t;

    typedef struct packed {
        pr_idx_t [NUM_SUPER-1:0] T_idx;
    } FL_ROB_OUT_t;

endpackage

// File: rtl/fl_popcount.sv
// Prefix popcount: prefix[i] counts set bits strictly below i, total counts all of them.
module fl_popcount #(
    parameter int N  = 2,
    parameter int CW = 2
) (
    input  logic [N-1:0]         bits,
    output logic [N-1:0][CW-1:0] prefix,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i] = acc;
            acc       = acc + CW'(bits[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers: compacted multi-way grant, packed retire
// push, and single-cycle rollback that frees every uncommitted PR by moving head.
module free_list
    import free_list_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           en,
    input  logic [NUM_SUPER-1:0]           dispatch_en,
    input  logic [NUM_SUPER-1:0]           retire_en,
    input  logic [NUM_SUPER-1:0][PR_W-1:0] Told_idx,
    input  logic                           rollback_en,
    output logic [NUM_SUPER-1:0][PR_W-1:0] T_idx,
    output logic                           free_valid,
    output logic [CNT_W-1:0]               free_count
);

    pr_idx_t                      ring [NUM_FL];
    logic [FL_W-1:0]              head;
    logic [FL_W-1:0]              tail;
    logic [CNT_W-1:0]             count;

    logic [NUM_SUPER-1:0][SC_W-1:0] disp_prefix;
    logic [NUM_SUPER-1:0][SC_W-1:0] ret_prefix;
    logic [SC_W-1:0]                disp_total;
    logic [SC_W-1:0]                ret_total;
    logic [SC_W-1:0]                pop_size;
    logic [FL_W-1:0]                tail_next;

    fl_popcount #(.N(NUM_SUPER), .CW(SC_W)) u_disp_count (
        .bits   (dispatch_en),
        .prefix (disp_prefix),
        .total  (disp_total)
    );

    fl_popcount #(.N(NUM_SUPER), .CW(SC_W)) u_ret_count (
        .bits   (retire_en),
        .prefix (ret_prefix),
        .total  (ret_total)
    );

    // Grants read the ring as it stood at the start of the cycle, so a same-cycle push is never bypassed.
    always_comb begin
        T_idx = '0;
        for (int i = 0; i < NUM_SUPER; i++) begin
            T_idx[i] = ring[head + FL_W'(disp_prefix[i])];
        end
    end

    // Dispatch is all-or-nothing and suppressed entirely while rolling back.
    always_comb begin
        pop_size = '0;
        if (!rollback_en && (CNT_W'(disp_total) <= count)) begin
            pop_size = disp_total;
        end
        tail_next = tail + FL_W'(ret_total);
    end

    assign free_valid = (count >= CNT_W'(NUM_SUPER));
    assign free_count = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_FL; k++) begin
                ring[k] <= `SD pr_idx_t'(`FL_RESET(k));
            end
            head  <= `SD '0;
            tail  <= `SD '0;
            count <= `SD CNT_W'(NUM_FL);
        end else if (en) begin
            for (int j = 0; j < NUM_SUPER; j++) begin
                if (retire_en[j]) begin
                    ring[tail + FL_W'(ret_prefix[j])] <= `SD Told_idx[j];
                end
            end
            tail <= `SD tail_next;
            // Everything between the new tail and the old head belongs to squashed work.
            if (rollback_en) begin
                head  <= `SD tail_next;
                count <= `SD CNT_W'(NUM_FL);
            end else begin
                head  <= `SD head + FL_W'(pop_size);
                count <= `SD count + CNT_W'(ret_total) - CNT_W'(pop_size);
            end
        end
    end

endmodule
